// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared ALU and one memory port.
// Optional build macro TRAP_ON_ILLEGAL_EN: illegal instructions halt instead of acting as NOPs.
module multicycle_control_unit #(
    parameter int unsigned N            = 32,
    parameter int unsigned MEM_WAIT_MAX = 0,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     instruction_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic             ir_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             iord_o,
    output logic             reg_write_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       pc_src_o,
    output logic [1:0]       wb_sel_o,
    output logic             halted_o,
    output logic             illegal_instr_o,
    output logic             mem_fault_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [4:0] OpLoad   = 5'b00000;
    localparam logic [4:0] OpImm    = 5'b00100;
    localparam logic [4:0] OpAuipc  = 5'b00101;
    localparam logic [4:0] OpStore  = 5'b01000;
    localparam logic [4:0] OpR      = 5'b01100;
    localparam logic [4:0] OpLui    = 5'b01101;
    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpJalr   = 5'b11001;
    localparam logic [4:0] OpJal    = 5'b11011;
    localparam logic [4:0] OpSystem = 5'b11100;

    localparam int unsigned WdW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    state_e           state_q, state_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_fault_q, mem_fault_d;
`ifdef TRAP_ON_ILLEGAL_EN
    logic             illegal_q, illegal_d;
`endif

    logic [4:0] opcode;
    logic       sys_ok;
    logic       legal_op;
    logic       illegal;

    assign opcode = instruction_i[6:2];

    // Only ECALL / EBREAK are accepted from the SYSTEM space.
    assign sys_ok = (instruction_i[14:12] == 3'b000) && (instruction_i[19:7] == 13'd0) &&
                    ((instruction_i[31:20] == 12'h000) || (instruction_i[31:20] == 12'h001));

    always_comb begin
        legal_op = 1'b0;
        case (opcode)
            OpLoad, OpImm, OpAuipc, OpStore, OpR,
            OpLui, OpBranch, OpJalr, OpJal: legal_op = 1'b1;
            OpSystem:                       legal_op = sys_ok;
            default:                        legal_op = 1'b0;
        endcase
    end

    assign illegal = (instruction_i[1:0] != 2'b11) || !legal_op;

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        retired_d   = retired_q;
        mem_fault_d = mem_fault_q;
`ifdef TRAP_ON_ILLEGAL_EN
        illegal_d   = illegal_q;
`endif
        case (state_q)
            StFetch: if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                if (illegal) begin
`ifdef TRAP_ON_ILLEGAL_EN
                    state_d   = StHalt;
                    illegal_d = 1'b1;
`else
                    state_d   = StFetch;
`endif
                end else if (opcode == OpSystem) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (opcode)
                    OpLoad, OpStore:             state_d = StMem;
                    OpR, OpImm, OpLui, OpAuipc:  state_d = StWb;
                    default:                     state_d = StFetch;
                endcase
            end
            StMem: if (mem_ready_i) state_d = (opcode == OpLoad) ? StWb : StFetch;
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase

        // MEM_WAIT_MAX wait cycles are tolerated; a further low cycle trips the watchdog.
        if ((MEM_WAIT_MAX != 0) && ((state_q == StFetch) || (state_q == StMem)) && !mem_ready_i) begin
            if (wd_q == WdW'(MEM_WAIT_MAX)) begin
                state_d     = StHalt;
                mem_fault_d = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
        if (state_d != state_q) wd_d = '0;

        if ((state_d == StFetch) &&
            ((state_q == StExec) || (state_q == StMem) || (state_q == StWb))) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StFetch;
            wd_q        <= '0;
            retired_q   <= '0;
            mem_fault_q <= 1'b0;
`ifdef TRAP_ON_ILLEGAL_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            retired_q   <= retired_d;
            mem_fault_q <= mem_fault_d;
`ifdef TRAP_ON_ILLEGAL_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        ir_write_o      = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        iord_o          = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 2'b00;
        alu_src_b_o     = 2'b00;
        alu_op_o        = 2'b00;
        pc_src_o        = 2'b00;
        wb_sel_o        = 2'b00;
        case (state_q)
            StFetch: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                end
            end
            // ALUOut captures old_pc + imm, the branch / JAL target.
            StDecode: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b10;
            end
            StExec: begin
                case (opcode)
                    OpR: begin
                        alu_src_a_o = 2'b01;
                        alu_op_o    = 2'b10;
                    end
                    OpImm: begin
                        alu_src_a_o = 2'b01;
                        alu_src_b_o = 2'b10;
                        alu_op_o    = 2'b11;
                    end
                    OpLoad, OpStore: begin
                        alu_src_a_o = 2'b01;
                        alu_src_b_o = 2'b10;
                    end
                    OpBranch: begin
                        alu_src_a_o     = 2'b01;
                        alu_op_o        = 2'b01;
                        pc_src_o        = 2'b01;
                        pc_write_cond_o = 1'b1;
                    end
                    OpJal: begin
                        pc_write_o  = 1'b1;
                        pc_src_o    = 2'b01;
                        reg_write_o = 1'b1;
                        wb_sel_o    = 2'b10;
                    end
                    OpJalr: begin
                        alu_src_a_o = 2'b01;
                        alu_src_b_o = 2'b10;
                        pc_write_o  = 1'b1;
                        reg_write_o = 1'b1;
                        wb_sel_o    = 2'b10;
                    end
                    OpLui: begin
                        alu_src_a_o = 2'b11;
                        alu_src_b_o = 2'b10;
                    end
                    OpAuipc: begin
                        alu_src_a_o = 2'b10;
                        alu_src_b_o = 2'b10;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                iord_o      = 1'b1;
                mem_read_o  = (opcode == OpLoad);
                mem_write_o = (opcode == OpStore);
            end
            StWb: begin
                reg_write_o = 1'b1;
                wb_sel_o    = (opcode == OpLoad) ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
        if (!rst_ni) begin
            pc_write_o      = 1'b0;
            pc_write_cond_o = 1'b0;
            ir_write_o      = 1'b0;
            mem_read_o      = 1'b0;
            mem_write_o     = 1'b0;
            iord_o          = 1'b0;
            reg_write_o     = 1'b0;
            alu_src_a_o     = 2'b00;
            alu_src_b_o     = 2'b00;
            alu_op_o        = 2'b00;
            pc_src_o        = 2'b00;
            wb_sel_o        = 2'b00;
        end
    end

`ifdef TRAP_ON_ILLEGAL_EN
    assign illegal_instr_o = illegal_q || (rst_ni && (state_q == StDecode) && illegal);
`else
    assign illegal_instr_o = rst_ni && (state_q == StDecode) && illegal;
`endif
    assign halted_o    = (state_q == StHalt);
    assign mem_fault_o = mem_fault_q;
    assign state_o     = state_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed and random instruction streams against a phase model.
module tb_multicycle_control_unit;

    localparam int CR = 0, CI = 1, CLD = 2, CST = 3, CBR = 4, CJAL = 5, CJALR = 6, CLUI = 7,
                   CAUIPC = 8, CILL = 10;

    typedef struct packed {
        logic       pcw, pcwc, irw, mrd, mwr, iord, rw;
        logic [1:0] a, b, op, psrc, wb;
    } ctl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, mem_ready = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, pc_src, wb_sel;
    logic        halted, illegal_instr, mem_fault;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        w_rst_n = 1'b0, w_mem_ready = 1'b0;
    logic [31:0] w_instr = 32'd0;
    logic        w_pc_write, w_pc_write_cond, w_ir_write, w_mem_read, w_mem_write, w_iord;
    logic        w_reg_write, w_halted, w_illegal_instr, w_mem_fault;
    logic [1:0]  w_alu_src_a, w_alu_src_b, w_alu_op, w_pc_src, w_wb_sel;
    logic [2:0]  w_state;
    logic [31:0] w_retired;

    multicycle_control_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .instruction_i(instr), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .ir_write_o(ir_write),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .iord_o(iord), .reg_write_o(reg_write),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .pc_src_o(pc_src),
        .wb_sel_o(wb_sel), .halted_o(halted), .illegal_instr_o(illegal_instr),
        .mem_fault_o(mem_fault), .state_o(state), .retired_o(retired)
    );

    multicycle_control_unit #(.MEM_WAIT_MAX(4)) dut_wd (
        .clk_i(clk), .rst_ni(w_rst_n), .instruction_i(w_instr), .mem_ready_i(w_mem_ready),
        .pc_write_o(w_pc_write), .pc_write_cond_o(w_pc_write_cond), .ir_write_o(w_ir_write),
        .mem_read_o(w_mem_read), .mem_write_o(w_mem_write), .iord_o(w_iord),
        .reg_write_o(w_reg_write), .alu_src_a_o(w_alu_src_a), .alu_src_b_o(w_alu_src_b),
        .alu_op_o(w_alu_op), .pc_src_o(w_pc_src), .wb_sel_o(w_wb_sel), .halted_o(w_halted),
        .illegal_instr_o(w_illegal_instr), .mem_fault_o(w_mem_fault), .state_o(w_state),
        .retired_o(w_retired)
    );

    ctl_t obs;
    assign obs = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_src, wb_sel};

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_retired = 32'd0;

    function automatic logic rand_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Control table from the instruction-class / phase description (phase 0..5 = FETCH..HALT).
    function automatic ctl_t exp_ctl(int ph, int cls, logic rdy);
        ctl_t c = '0;
        case (ph)
            0: begin c.mrd = 1; c.b = 2'b01; if (rdy) begin c.irw = 1; c.pcw = 1; end end
            1: begin c.a = 2'b10; c.b = 2'b10; end
            2: case (cls)
                CR:       begin c.a = 2'b01; c.op = 2'b10; end
                CI:       begin c.a = 2'b01; c.b = 2'b10; c.op = 2'b11; end
                CLD, CST: begin c.a = 2'b01; c.b = 2'b10; end
                CBR:      begin c.a = 2'b01; c.op = 2'b01; c.psrc = 2'b01; c.pcwc = 1; end
                CJAL:     begin c.pcw = 1; c.psrc = 2'b01; c.rw = 1; c.wb = 2'b10; end
                CJALR:    begin c.a = 2'b01; c.b = 2'b10; c.pcw = 1; c.rw = 1; c.wb = 2'b10; end
                CLUI:     begin c.a = 2'b11; c.b = 2'b10; end
                CAUIPC:   begin c.a = 2'b10; c.b = 2'b10; end
                default: ;
            endcase
            3: begin c.iord = 1; if (cls == CLD) c.mrd = 1; else c.mwr = 1; end
            4: begin c.rw = 1; if (cls == CLD) c.wb = 2'b01; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] make_word(int cls);
        logic [31:0] w = $urandom();
        case (cls)
            CR:     w[6:0] = 7'b0110011;
            CI:     w[6:0] = 7'b0010011;
            CLD:    w[6:0] = 7'b0000011;
            CST:    w[6:0] = 7'b0100011;
            CBR:    w[6:0] = 7'b1100011;
            CJAL:   w[6:0] = 7'b1101111;
            CJALR:  w[6:0] = 7'b1100111;
            CLUI:   w[6:0] = 7'b0110111;
            CAUIPC: w[6:0] = 7'b0010111;
            default: case ($urandom_range(0, 2))
                0:       w[1:0] = 2'($urandom_range(0, 2));
                1:       w[6:0] = 7'b0001111;
                default: begin w[6:0] = 7'b1110011; w[14:12] = 3'($urandom_range(1, 7)); end
            endcase
        endcase
        return w;
    endfunction

    // Entered and left just after a rising edge.
    task automatic run_instr(input logic [31:0] word, input int cls, input int fw, input int mw,
                             input string name);
        int   ph[$];
        logic rq[$];
        ctl_t exp;
        logic exp_ill;
        for (int k = 0; k <= fw; k++) begin ph.push_back(0); rq.push_back(k == fw); end
        ph.push_back(1); rq.push_back(rand_bit());
        if (cls != CILL) begin
            ph.push_back(2); rq.push_back(rand_bit());
            if (cls == CLD || cls == CST)
                for (int k = 0; k <= mw; k++) begin ph.push_back(3); rq.push_back(k == mw); end
            if (cls == CR || cls == CI || cls == CLD || cls == CLUI || cls == CAUIPC) begin
                ph.push_back(4); rq.push_back(rand_bit());
            end
        end
        instr = word;
        for (int i = 0; i < ph.size(); i++) begin
            mem_ready = rq[i];
            @(negedge clk);
            exp     = exp_ctl(ph[i], cls, rq[i]);
            exp_ill = (cls == CILL) && (ph[i] == 1);
            n_checks++;
            if (state !== 3'(ph[i]))
                $display("FAIL %s cyc %0d state: got %0d exp %0d", name, i, state, ph[i]);
            else n_pass++;
            n_checks++;
            if ({obs, illegal_instr, halted, mem_fault} !== {exp, exp_ill, 2'b00})
                $display("FAIL %s cyc %0d ctl/flags: got %h exp %h", name, i,
                         {obs, illegal_instr, halted, mem_fault}, {exp, exp_ill, 2'b00});
            else n_pass++;
            @(posedge clk); #1;
        end
        if (cls != CILL) exp_retired++;
        n_checks++;
        if (retired !== exp_retired || state !== 3'd0)
            $display("FAIL %s retired/state: got %0d/%0d exp %0d/0", name, retired, state,
                     exp_retired);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; instr = 32'h002081B3;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (obs !== '0 || illegal_instr !== 1'b0)
                $display("FAIL reset strobes: got %h exp 0", obs);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b1; exp_retired = 0;
        n_checks++;
        if ({state, retired, halted, mem_fault, illegal_instr} !== 38'd0)
            $display("FAIL reset state: got st=%0d ret=%0d h=%b f=%b i=%b exp all 0", state,
                     retired, halted, mem_fault, illegal_instr);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_instr(32'h002081B3, CR, 0, 0, "add");
        run_instr(32'h0000A183, CLD, 0, 2, "lw_wait");
        run_instr(32'h00208463, CBR, 0, 0, "beq");
        run_instr(32'h008000EF, CJAL, 0, 0, "jal");
        run_instr(32'h002081B3, CR, 10, 0, "long_fetch_wait");
    endtask

    task automatic test_random();
        int cls;
        for (int n = 0; n < 60; n++) begin
            cls = $urandom_range(0, 9);
`ifdef TRAP_ON_ILLEGAL_EN
            if (cls == 9) cls = CR;
`else
            if (cls == 9) cls = CILL;
`endif
            run_instr(make_word(cls), cls, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end
    endtask

    task automatic test_reset_abort();
        instr = 32'h0020A023;
        mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (state !== 3'd3 || mem_write !== 1'b1)
            $display("FAIL abort store: got st=%0d wr=%b exp 3/1", state, mem_write);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== '0) $display("FAIL abort forced: got %h exp 0", obs);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        exp_retired = 0;
        n_checks++;
        if (state !== 3'd0 || mem_write !== 1'b0 || mem_read !== 1'b1 || retired !== 32'd0)
            $display("FAIL abort after: got st=%0d wr=%b rd=%b ret=%0d exp 0/0/1/0", state,
                     mem_write, mem_read, retired);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
`ifdef TRAP_ON_ILLEGAL_EN
        instr = 32'h0000007F; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (state !== 3'd1 || illegal_instr !== 1'b1)
            $display("FAIL illegal decode: got st=%0d ill=%b exp 1/1", state, illegal_instr);
        else n_pass++;
        repeat (5) begin
            @(posedge clk); #1; mem_ready = rand_bit(); instr = $urandom();
            @(negedge clk);
            n_checks++;
            if ({state, halted, illegal_instr, obs} !== {3'd5, 2'b11, 17'd0})
                $display("FAIL illegal trap: got st=%0d h=%b ill=%b ctl=%h exp 5/1/1/0", state,
                         halted, illegal_instr, obs);
            else n_pass++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; exp_retired = 0;
`else
        run_instr(32'h0000007F, CILL, 0, 0, "illegal_nop");
`endif
    endtask

    task automatic test_ecall();
        instr = 32'h00000073; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (state !== 3'd1 || illegal_instr !== 1'b0)
            $display("FAIL ecall decode: got st=%0d ill=%b exp 1/0", state, illegal_instr);
        else n_pass++;
        repeat (20) begin
            @(posedge clk); #1; mem_ready = rand_bit();
            @(negedge clk);
            n_checks++;
            if ({state, halted, obs} !== {3'd5, 1'b1, 17'd0})
                $display("FAIL ecall halt: got st=%0d h=%b ctl=%h exp 5/1/0", state, halted, obs);
            else n_pass++;
        end
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b0; exp_retired = 0;
        @(negedge clk);
        n_checks++;
        if ({state, retired, halted, mem_read} !== {3'd0, 32'd0, 1'b0, 1'b1})
            $display("FAIL ecall reset: got st=%0d ret=%0d h=%b rd=%b exp 0/0/0/1", state,
                     retired, halted, mem_read);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_watchdog();
        int exp_st[];
        w_rst_n = 1'b0; w_mem_ready = 1'b0; w_instr = 32'h002081B3;
        repeat (2) begin @(posedge clk); #1; end
        w_rst_n = 1'b1;
        // Exactly four wait cycles, ready on the fifth, then an ADD.
        exp_st = '{0, 0, 0, 0, 0, 1, 2, 4};
        for (int i = 0; i < exp_st.size(); i++) begin
            w_mem_ready = (i >= 4);
            @(negedge clk);
            n_checks++;
            if (w_state !== 3'(exp_st[i]) || w_mem_fault !== 1'b0)
                $display("FAIL wd_ok cyc %0d: got st=%0d f=%b exp %0d/0", i, w_state,
                         w_mem_fault, exp_st[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        w_mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (i < 5 && {w_state, w_mem_fault, w_halted, w_mem_read} !== {3'd0, 3'b001})
                $display("FAIL wd_wait cyc %0d: got st=%0d f=%b h=%b exp 0/0/0", i, w_state,
                         w_mem_fault, w_halted);
            else if (i >= 5 && {w_state, w_mem_fault, w_halted, w_mem_read} !== {3'd5, 3'b110})
                $display("FAIL wd_trip cyc %0d: got st=%0d f=%b h=%b exp 5/1/1", i, w_state,
                         w_mem_fault, w_halted);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (w_retired !== 32'd1) $display("FAIL wd_retired: got %0d exp 1", w_retired);
        else n_pass++;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_reset_abort();
        test_illegal();
        test_ecall();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle RV32I control FSM that replaces the single-cycle decoder: it sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared ALU and a single variable-latency memory port. It sits between the instruction register and the multi-cycle datapath (PC, old_pc, IR, MDR, ALUOut registers). It adds three things the single-cycle decoder lacks: a memory ready handshake with an optional watchdog, halt on ECALL/EBREAK, and a retired-instruction counter.

## Interface
- N, 32: instruction width; only bits [31:0] are decoded; must be ≥32.
- MEM_WAIT_MAX, 0: maximum wait cycles on mem_ready per access; 0 = unlimited, no watchdog.
- CNT_W, 32: retired-instruction counter width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- Instruction  in  N  IR contents; valid from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write, pc_write_cond, ir_write  out  1  PC write, conditional PC write (datapath ANDs with branch-taken), IR/old_pc load.
- mem_read, mem_write, iord  out  1  memory strobes; iord=1 selects ALUOut as address, 0 selects PC.
- reg_write  out  1  register-file write.
- alu_src_a  out  2  00 PC, 01 rs1, 10 old_pc, 11 zero.
- alu_src_b  out  2  00 rs2, 01 const 4, 10 imm.
- ALUOp  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct.
- pc_src  out  2  00 ALU result, 01 ALUOut.
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC.
- halted, illegal_instr, mem_fault  out  1  status flags.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- retired  out  CNT_W  count of completed instructions.

## Operation
- Outputs are decoded from the state register, plus Instruction[6:2] in EXEC/MEM/WB. Strobes and selects not listed for a state are 0.
- FETCH: mem_read=1, a=PC, b=4, ALUOp=00, pc_src=00. On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise hold in FETCH.
- DECODE: a=old_pc, b=imm, ALUOp=00, so ALUOut holds the branch/JAL target. Instruction[1:0]≠11 or an unknown opcode is illegal: illegal_instr=1 for that cycle.
- Legal SYSTEM (funct3=000, ECALL or EBREAK) → HALT. Any other SYSTEM is illegal. All other legal opcodes → EXEC.
- EXEC by opcode:
  - R (01100): a=rs1, b=rs2, ALUOp=10 → WB.
  - I-ALU (00100): a=rs1, b=imm, ALUOp=11 → WB.
  - LOAD (00000) / STORE (01000): a=rs1, b=imm, ALUOp=00 → MEM.
  - BRANCH (11000): a=rs1, b=rs2, ALUOp=01, pc_src=01, pc_write_cond=1 → FETCH.
  - JAL (11011): pc_write=1, pc_src=01, reg_write=1, wb_sel=10 → FETCH.
  - JALR (11001): a=rs1, b=imm, ALUOp=00, pc_src=00, pc_write=1, reg_write=1, wb_sel=10 → FETCH.
  - LUI (01101): a=zero, b=imm → WB. AUIPC (00101): a=old_pc, b=imm → WB.
- MEM: iord=1; mem_read=1 for a load, mem_write=1 for a store. Hold until mem_ready. Then a load → WB, a store → FETCH.
- WB: reg_write=1; wb_sel=01 for a load, 00 otherwise → FETCH.
- retired increments by 1 on every transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^CNT_W.
- HALT: all strobes 0, halted=1. Only rst_n leaves HALT.
- Watchdog (MEM_WAIT_MAX>0): a counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0 in those states. When the counter reaches MEM_WAIT_MAX with mem_ready still 0 → HALT, and mem_fault=1 (sticky).

## Timing
- Cycles per instruction with zero wait states:
  - branch 3; JAL/JALR 3.
  - R/I-ALU/LUI/AUIPC 4; store 4.
  - load 5.
- Each cycle mem_ready is low in FETCH or MEM adds one cycle.
- mem_ready is sampled only in FETCH and MEM; it is ignored elsewhere.
- JAL/JALR write rd and PC on the same edge; rd receives the pre-edge PC, which is old_pc+4.
- Reset: while rst_n=0 at an edge, state←FETCH, retired←0, halted/mem_fault/illegal flag←0, watchdog←0. In the same cycle all strobes are forced 0 combinationally.
- Reset during MEM or HALT aborts the access; no write strobe is issued after the reset edge. The first FETCH strobe appears in the first cycle with rst_n=1.

## Configuration
- TRAP_ON_ILLEGAL_EN defined: an illegal instruction in DECODE → HALT; illegal_instr and halted stay 1 until reset.
- TRAP_ON_ILLEGAL_EN undefined: an illegal instruction → FETCH as a NOP. illegal_instr pulses for the DECODE cycle only, and retired does not increment.

## Test plan
- ADD x3,x1,x2 (0x002081B3), mem_ready=1 → states 0,1,2,4,0; reg_write=1 only in WB with wb_sel=00; retired 0→1.
- LW (0x0000A183) with mem_ready low for 2 MEM cycles → MEM held 3 cycles, mem_read=iord=1 throughout; WB wb_sel=01; total 7 cycles.
- BEQ (0x00208463) → EXEC asserts pc_write_cond=1, pc_src=01, ALUOp=01, reg_write=0; back to FETCH after 3 cycles.
- JAL x1 (0x008000EF) → EXEC asserts pc_write=1, reg_write=1, wb_sel=10 in the same cycle.
- ECALL (0x00000073) → HALT, halted=1, all strobes 0 for 20 cycles. Then rst_n low for 1 edge → state=0, retired=0.
- MEM_WAIT_MAX=4 with mem_ready held low in FETCH → HALT after the 4-cycle limit, mem_fault=1. Opcode 0x0000007F: with the macro → HALT and illegal_instr=1; without → FETCH, retired unchanged.
